// File: rtl/fp_div_pkg.sv
// Shared state/class types and field helpers for the sequential FP divider.
// Helpers work on a 64-bit scratch word so one set serves every EXP_W/MAN_W.
package fp_div_pkg;

    localparam int unsigned MAX_W = 64;

    typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, ROUND, DONE} state_t;
    typedef enum logic [1:0] {ZERO, NORM, INF, NAN} op_class_t;

    function automatic int unsigned bias(input int unsigned exp_w);
        return (32'd1 << (exp_w - 1)) - 32'd1;
    endfunction

    function automatic logic [MAX_W-1:0] exp_ones(input int unsigned exp_w);
        return (MAX_W'(1) << exp_w) - MAX_W'(1);
    endfunction

    function automatic logic [MAX_W-1:0] qnan_word(input int unsigned exp_w,
                                                   input int unsigned man_w);
        return (exp_ones(exp_w) << man_w) | (MAX_W'(1) << (man_w - 1));
    endfunction

    function automatic logic [MAX_W-1:0] inf_word(input logic        sign,
                                                  input int unsigned exp_w,
                                                  input int unsigned man_w);
        return (MAX_W'(sign) << (exp_w + man_w)) | (exp_ones(exp_w) << man_w);
    endfunction

    // Subnormals classify as ZERO: the divider runs denormals-are-zero.
    function automatic op_class_t classify(input logic [MAX_W-1:0] exp_field,
                                           input logic             frac_nz,
                                           input int unsigned      exp_w);
        if (exp_field == '0)
            return ZERO;
        if (exp_field == exp_ones(exp_w))
            return frac_nz ? NAN : INF;
        return NORM;
    endfunction

endpackage

// File: rtl/fp_div_iter_core.sv
// Restoring radix-2 significand divider: one quotient bit per cycle,
// MAN_W+3 bits total with the integer bit first, plus a remainder sticky.
module fp_div_iter_core
    import fp_div_pkg::*;
#(
    parameter int unsigned MAN_W = 23
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [MAN_W:0]   dividend,
    input  logic [MAN_W:0]   divisor,
    output logic [MAN_W+2:0] q,
    output logic             sticky,
    output logic             done
);

    localparam int unsigned STEPS = MAN_W + 3;
    localparam int unsigned CNT_W = $clog2(STEPS);

    logic [MAN_W+1:0] rem;
    logic [MAN_W+1:0] trial;
    logic [MAN_W+1:0] rem_next;
    logic [MAN_W:0]   dvs;
    logic [CNT_W-1:0] cnt;
    logic             busy;
    logic             fits;

    always_comb begin
        trial    = rem - {1'b0, dvs};
        fits     = (rem >= {1'b0, dvs});
        rem_next = fits ? trial : rem;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem  <= '0;
            dvs  <= '0;
            q    <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            rem  <= {1'b0, dividend};
            dvs  <= divisor;
            q    <= '0;
            cnt  <= CNT_W'(STEPS - 1);
            busy <= 1'b1;
        end else if (busy) begin
            // Partial remainder stays below 2*divisor, so the shift never loses a set bit.
            rem <= rem_next << 1;
            q   <= {q[MAN_W+1:0], fits};
            if (cnt == '0)
                busy <= 1'b0;
            else
                cnt <= cnt - 1'b1;
        end
    end

    assign sticky = |rem;
    assign done   = busy && (cnt == '0);

endmodule

// File: rtl/fp_div_seq.sv
// Multi-cycle IEEE-754-style divider a/b with valid/ready on both sides,
// round-to-nearest-even, DAZ/FTZ and exception flags.
module fp_div_seq
    import fp_div_pkg::*;
#(
    parameter  int unsigned EXP_W = 8,
    parameter  int unsigned MAN_W = 23,
    localparam int unsigned W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         flag_invalid,
    output logic         flag_div_zero,
    output logic         flag_overflow,
    output logic         flag_underflow
);

    localparam logic [MAX_W-1:0]        QNAN_FULL = qnan_word(EXP_W, MAN_W);
    localparam logic [MAX_W-1:0]        INF_FULL  = inf_word(1'b0, EXP_W, MAN_W);
    localparam logic [W-1:0]            QNAN      = QNAN_FULL[W-1:0];
    localparam logic [W-2:0]            INF_MAG   = INF_FULL[W-2:0];
    localparam logic [EXP_W+1:0]        E_BIAS    = (EXP_W+2)'(bias(EXP_W));
    localparam logic signed [EXP_W+1:0] E_MAX     = {2'b00, {EXP_W{1'b1}}};
    localparam logic signed [EXP_W+1:0] E_ONE     = (EXP_W+2)'(1);

    state_t                  state;
    logic [W-1:0]            a_q;
    logic [W-1:0]            b_q;
    logic                    sign_q;
    logic signed [EXP_W+1:0] e_q;

    op_class_t               cls_a;
    op_class_t               cls_b;
    logic                    sign_ab;
    logic signed [EXP_W+1:0] e_calc;
    logic                    spec_hit;
    logic [W-1:0]            spec_res;
    logic                    spec_inv;
    logic                    spec_dz;

    logic                    core_start;
    logic                    core_done;
    logic                    core_sticky;
    logic [MAN_W+2:0]        core_q;

    logic [MAN_W+2:0]        norm_q;
    logic signed [EXP_W+1:0] e_n;
    logic signed [EXP_W+1:0] e_r;
    logic                    round_up;
    logic [MAN_W+1:0]        sig_r;
    logic [MAN_W-1:0]        frac_r;
    logic                    ovf;
    logic                    unf;
    logic [W-1:0]            round_res;

    // Operand classification and special-case resolution in priority order.
    always_comb begin
        cls_a    = classify(MAX_W'(a_q[W-2:MAN_W]), |a_q[MAN_W-1:0], EXP_W);
        cls_b    = classify(MAX_W'(b_q[W-2:MAN_W]), |b_q[MAN_W-1:0], EXP_W);
        sign_ab  = a_q[W-1] ^ b_q[W-1];
        e_calc   = $signed({2'b00, a_q[W-2:MAN_W]}) - $signed({2'b00, b_q[W-2:MAN_W]})
                   + $signed(E_BIAS);
        spec_hit = 1'b1;
        spec_res = '0;
        spec_inv = 1'b0;
        spec_dz  = 1'b0;
        if (cls_a == NAN || cls_b == NAN) begin
            spec_res = QNAN;
        end else if ((cls_a == ZERO && cls_b == ZERO) || (cls_a == INF && cls_b == INF)) begin
            spec_res = QNAN;
            spec_inv = 1'b1;
        end else if (cls_a == INF) begin
            spec_res = {sign_ab, INF_MAG};
        end else if (cls_b == ZERO) begin
            spec_res = {sign_ab, INF_MAG};
            spec_dz  = 1'b1;
        end else if (cls_a == ZERO || cls_b == INF) begin
            spec_res = {sign_ab, {(W-1){1'b0}}};
        end else begin
            spec_hit = 1'b0;
        end
    end

    assign core_start = (state == UNPACK) && !spec_hit;

    fp_div_iter_core #(
        .MAN_W(MAN_W)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (core_start),
        .dividend ({1'b1, a_q[MAN_W-1:0]}),
        .divisor  ({1'b1, b_q[MAN_W-1:0]}),
        .q        (core_q),
        .sticky   (core_sticky),
        .done     (core_done)
    );

    // Normalise, round to nearest even, then saturate to inf or flush to zero.
    always_comb begin
        if (core_q[MAN_W+2]) begin
            norm_q = core_q;
            e_n    = e_q;
        end else begin
            norm_q = {core_q[MAN_W+1:0], 1'b0};
            e_n    = e_q - E_ONE;
        end
        round_up = norm_q[1] & (norm_q[0] | core_sticky | norm_q[2]);
        sig_r    = {1'b0, norm_q[MAN_W+2:2]} + (MAN_W+2)'(round_up);
        if (sig_r[MAN_W+1]) begin
            frac_r = sig_r[MAN_W:1];
            e_r    = e_n + E_ONE;
        end else begin
            frac_r = sig_r[MAN_W-1:0];
            e_r    = e_n;
        end
        ovf = (e_r >= E_MAX);
        unf = !ovf && (e_r[EXP_W+1] || (e_r == '0));
        if (ovf)
            round_res = {sign_q, INF_MAG};
        else if (unf)
            round_res = {sign_q, {(W-1){1'b0}}};
        else
            round_res = {sign_q, e_r[EXP_W-1:0], frac_r};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            in_ready       <= 1'b1;
            out_valid      <= 1'b0;
            result         <= '0;
            flag_invalid   <= 1'b0;
            flag_div_zero  <= 1'b0;
            flag_overflow  <= 1'b0;
            flag_underflow <= 1'b0;
            a_q            <= '0;
            b_q            <= '0;
            sign_q         <= 1'b0;
            e_q            <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= a;
                        b_q      <= b;
                        in_ready <= 1'b0;
                        state    <= UNPACK;
                    end
                end
                UNPACK: begin
                    sign_q <= sign_ab;
                    e_q    <= e_calc;
                    if (spec_hit) begin
                        result        <= spec_res;
                        flag_invalid  <= spec_inv;
                        flag_div_zero <= spec_dz;
                        state         <= DONE;
                    end else begin
                        state <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    if (core_done)
                        state <= ROUND;
                end
                ROUND: begin
                    result         <= round_res;
                    flag_overflow  <= ovf;
                    flag_underflow <= unf;
                    out_valid      <= 1'b1;
                    state          <= DONE;
                end
                DONE: begin
                    // Special cases enter with out_valid low; it rises one edge later.
                    if (out_valid && out_ready) begin
                        out_valid      <= 1'b0;
                        flag_invalid   <= 1'b0;
                        flag_div_zero  <= 1'b0;
                        flag_overflow  <= 1'b0;
                        flag_underflow <= 1'b0;
                        in_ready       <= 1'b1;
                        state          <= IDLE;
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed bench for fp_div_seq at (8,23) and (5,10) against an exact-quotient
// reference model; literal expectations pin the model itself.
module tb_fp_div_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        iv0, ir0, ov0, ordy0, fi0, fd0, fo0, fu0;
    logic [31:0] a0, b0, r0;
    logic        iv1, ir1, ov1, ordy1, fi1, fd1, fo1, fu1;
    logic [15:0] a1, b1, r1;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [67:0] exp0, exp1;
    logic        chk0, chk1;

    fp_div_seq dut_sp (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
        .out_valid(ov0), .out_ready(ordy0), .result(r0), .flag_invalid(fi0),
        .flag_div_zero(fd0), .flag_overflow(fo0), .flag_underflow(fu0)
    );

    fp_div_seq #(.EXP_W(5), .MAN_W(10)) dut_hp (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
        .out_valid(ov1), .out_ready(ordy1), .result(r1), .flag_invalid(fi1),
        .flag_div_zero(fd1), .flag_overflow(fo1), .flag_underflow(fu1)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  fl;   // {invalid, div_zero, overflow, underflow}
        int          lat;
    } vec_t;

    vec_t sp_vecs [15] = '{
        '{32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28},
        '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 28},
        '{32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000, 28},
        '{32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 2},
        '{32'h00000000, 32'h80000000, 32'h7FC00000, 4'b1000, 2},
        '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 2},
        '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b1000, 2},
        '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0000, 2},
        '{32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000, 2},
        '{32'h3F800000, 32'h7F800000, 32'h00000000, 4'b0000, 2},
        '{32'h3F800000, 32'h80000000, 32'hFF800000, 4'b0100, 2},
        '{32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0010, 28},
        '{32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, 28},
        '{32'h80800000, 32'h40000000, 32'h80000000, 4'b0001, 28},
        '{32'h40490FDB, 32'h402DF854, 32'h3F93EEE0, 4'b0000, 28}
    };

    vec_t hp_vecs [4] = '{
        '{32'h3C00, 32'h4000, 32'h3800, 4'b0000, 15},
        '{32'h7BFF, 32'h3800, 32'h7C00, 4'b0010, 15},
        '{32'hBC00, 32'h4000, 32'hB800, 4'b0000, 15},
        '{32'h3C00, 32'h0000, 32'h7C00, 4'b0100, 2}
    };

    // Reference: exact rational quotient, then a single RNE step on the full remainder.
    function automatic logic [67:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input int ew, input int mw);
        logic [63:0]  emax, fmask, ea, eb, fa, fb, qnan, inf_w, zero_w, res;
        logic [127:0] num, den, q, r, rest, half, sig;
        logic         s, inv, dz, ovf, unf;
        int           ca, cb, e, sh;
        emax   = (64'(1) << ew) - 1;
        fmask  = (64'(1) << mw) - 1;
        s      = a[ew+mw] ^ b[ew+mw];
        ea     = (a >> mw) & emax;
        eb     = (b >> mw) & emax;
        fa     = a & fmask;
        fb     = b & fmask;
        ca     = (ea == 0) ? 0 : (ea == emax) ? ((fa != 0) ? 3 : 2) : 1;
        cb     = (eb == 0) ? 0 : (eb == emax) ? ((fb != 0) ? 3 : 2) : 1;
        qnan   = (emax << mw) | (64'(1) << (mw - 1));
        inf_w  = (64'(s) << (ew + mw)) | (emax << mw);
        zero_w = 64'(s) << (ew + mw);
        inv = 1'b0; dz = 1'b0; ovf = 1'b0; unf = 1'b0; res = '0;
        if (ca == 3 || cb == 3) begin
            res = qnan;
        end else if ((ca == 0 && cb == 0) || (ca == 2 && cb == 2)) begin
            res = qnan; inv = 1'b1;
        end else if (ca == 2) begin
            res = inf_w;
        end else if (cb == 0) begin
            res = inf_w; dz = 1'b1;
        end else if (ca == 0 || cb == 2) begin
            res = zero_w;
        end else begin
            num  = 128'(fa | (64'(1) << mw));
            den  = 128'(fb | (64'(1) << mw));
            sh   = (num < den) ? 1 : 0;
            e    = int'(ea) - int'(eb) + ((1 << (ew - 1)) - 1) - sh;
            num  = num << (64 + sh);
            q    = num / den;
            r    = num % den;
            rest = q & ((128'(1) << (64 - mw)) - 1);
            half = 128'(1) << (63 - mw);
            sig  = q >> (64 - mw);
            if (rest > half || (rest == half && (r != 0 || sig[0])))
                sig = sig + 1;
            if (sig == (128'(2) << mw)) begin
                sig = sig >> 1;
                e   = e + 1;
            end
            if (e >= int'(emax)) begin
                res = inf_w; ovf = 1'b1;
            end else if (e <= 0) begin
                res = zero_w; unf = 1'b1;
            end else begin
                res = (64'(s) << (ew + mw)) | (64'(e) << mw) | (sig[63:0] & fmask);
            end
        end
        return {inv, dz, ovf, unf, res};
    endfunction

    task automatic check(input string name, input logic [71:0] got, input logic [71:0] want);
        vec_cnt++;
        if (got !== want) begin
            err_cnt++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    function automatic logic outv(input int inst);
        return (inst == 0) ? ov0 : ov1;
    endfunction

    function automatic logic inr(input int inst);
        return (inst == 0) ? ir0 : ir1;
    endfunction

    task automatic drive(input int inst, input logic v, input logic [63:0] a, input logic [63:0] b);
        if (inst == 0) begin
            iv0 = v; a0 = a[31:0]; b0 = b[31:0];
        end else begin
            iv1 = v; a1 = a[15:0]; b1 = b[15:0];
        end
    endtask

    // Issue one op and measure edges from the accept edge to out_valid.
    task automatic run_op(input int inst, input string name, input vec_t v);
        logic [67:0] m;
        int          n;
        m = (inst == 0) ? model(64'(v.a), 64'(v.b), 8, 23) : model(64'(v.a), 64'(v.b), 5, 10);
        check({name, "_model"}, 72'(m), 72'({v.fl, 32'h0, v.res}));
        if (inst == 0) begin exp0 = m; chk0 = 1'b1; end
        else           begin exp1 = m; chk1 = 1'b1; end
        n = 0;
        while (!inr(inst) && n < 50) begin @(posedge clk); #1; n++; end
        drive(inst, 1'b1, 64'(v.a), 64'(v.b));
        @(posedge clk); #1;
        drive(inst, 1'b0, 64'(v.a), 64'(v.b));
        n = 0;
        while (!outv(inst) && n < 60) begin @(posedge clk); #1; n++; end
        check({name, "_latency"}, 72'(n), 72'(v.lat));
    endtask

    task automatic finish_op(input int inst, input string name);
        @(posedge clk); #1;
        check({name, "_return_idle"}, 72'({outv(inst), inr(inst)}), 72'(2'b01));
        if (inst == 0) chk0 = 1'b0;
        else           chk1 = 1'b0;
    endtask

    // Every cycle a result is presented it must equal the model's answer.
    always @(negedge clk) begin
        if (rst_n && chk0 && ov0)
            check("sp_result", 72'({fi0, fd0, fo0, fu0, 32'h0, r0}), 72'(exp0));
        if (rst_n && chk1 && ov1)
            check("hp_result", 72'({fi1, fd1, fo1, fu1, 48'h0, r1}), 72'(exp1));
    end

    initial begin
        rst_n = 1'b0;
        iv0 = 1'b0; a0 = '0; b0 = '0; ordy0 = 1'b1;
        iv1 = 1'b0; a1 = '0; b1 = '0; ordy1 = 1'b1;
        chk0 = 1'b0; chk1 = 1'b0;
        exp0 = '0; exp1 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_sp", 72'({ov0, ir0, fi0, fd0, fo0, fu0, r0}), 72'({2'b01, 4'b0000, 32'h0}));
        check("reset_hp", 72'({ov1, ir1, fi1, fd1, fo1, fu1, r1}), 72'({2'b01, 4'b0000, 16'h0}));
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            run_op(0, $sformatf("sp%0d", i), sp_vecs[i]);
            finish_op(0, $sformatf("sp%0d", i));
        end
        for (int i = 0; i < 4; i++) begin
            run_op(1, $sformatf("hp%0d", i), hp_vecs[i]);
            finish_op(1, $sformatf("hp%0d", i));
        end

        // Backpressure: result held, new operands refused while DONE.
        ordy0 = 1'b0;
        run_op(0, "bp", sp_vecs[0]);
        for (int i = 0; i < 5; i++) begin
            drive(0, 1'b1, 64'h3F800000, 64'h40400000);
            check("bp_in_ready", 72'(ir0), 72'(0));
            @(posedge clk); #1;
            check("bp_out_valid", 72'(ov0), 72'(1));
        end
        ordy0 = 1'b1;
        @(posedge clk); #1;
        drive(0, 1'b0, 64'h0, 64'h0);
        check("bp_release", 72'({ov0, ir0}), 72'(2'b01));
        chk0 = 1'b0;
        @(posedge clk); #1;
        check("bp_no_accept", 72'({ov0, ir0}), 72'(2'b01));

        // Synchronous reset at divide iteration 10 discards the op.
        drive(0, 1'b1, 64'h40C00000, 64'h40000000);
        @(posedge clk); #1;
        drive(0, 1'b0, 64'h0, 64'h0);
        repeat (11) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("mid_reset", 72'({ov0, ir0, fi0, fd0, fo0, fu0, r0}), 72'({2'b01, 4'b0000, 32'h0}));
        run_op(0, "post_reset", sp_vecs[0]);
        finish_op(0, "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
